// File: rtl/devbus_pkg.sv
// Shared types and constants for the device-bus arbiter.
package devbus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic M_CPU = 1'b0;
    localparam logic M_DBG = 1'b1;

    localparam int ADDR_W_DEF = 30;
    localparam int CNT_W      = 8;

endpackage

// File: rtl/devbus_arbiter_rr_arb2.sv
// Two-way round-robin pick with an optional sticky lock owner.
module rr_arb2
    import devbus_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    input  logic lock_hold,
    input  logic lock_owner,
    output logic valid,
    output logic winner
);

    logic owner_req;
    logic both;

    assign owner_req = lock_owner ? req1 : req0;
    assign both      = req0 && req1;

    always_comb begin
        valid  = req0 || req1;
        winner = M_CPU;
        priority case (1'b1)
            (lock_hold && owner_req): winner = lock_owner;
            both:                     winner = ~last_grant;
            default:                  winner = req1;
        endcase
    end

endmodule

// File: rtl/devbus_arbiter.sv
// Two-master arbiter and transfer sequencer for the device bus.
// Build option: DEVBUS_LOCK_EN adds m0_lock/m1_lock bus locking.
module devbus_arbiter
    import devbus_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int ADDR_W  = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef DEVBUS_LOCK_EN
    input  logic              m0_lock,
    input  logic              m1_lock,
`endif
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic              m0_we,
    input  logic [31:0]       m0_wd,
    output logic              m0_ack,
    output logic [31:0]       m0_rd,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic              m1_we,
    input  logic [31:0]       m1_wd,
    output logic              m1_ack,
    output logic [31:0]       m1_rd,
    output logic              m1_err,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_wd,
    output logic              bus_we,
    input  logic [31:0]       bus_rd,
    input  logic              bus_ready,
    output logic              busy,
    output logic              grant
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state;
    state_t            state_d;
    logic              grant_q;
    logic              last_grant;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [31:0]       wd_q;
    logic [31:0]       rd_q;
    logic              err_q;
    logic [CNT_W-1:0]  cnt;
    logic              arb_valid;
    logic              winner;
    logic              lock_hold;
    logic              lock_owner;
    logic              expired;
    logic              resp;

    rr_arb2 u_arb (
        .req0       (m0_req),
        .req1       (m1_req),
        .last_grant (last_grant),
        .lock_hold  (lock_hold),
        .lock_owner (lock_owner),
        .valid      (arb_valid),
        .winner     (winner)
    );

`ifdef DEVBUS_LOCK_EN
    logic win_lock;

    assign win_lock = winner ? m1_lock : m0_lock;

    // Lock follows whoever wins next: owner with lock=0, or the other master.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_hold  <= 1'b0;
            lock_owner <= M_CPU;
        end else if (state == IDLE && arb_valid) begin
            lock_hold  <= win_lock;
            lock_owner <= winner;
        end
    end
`else
    assign lock_hold  = 1'b0;
    assign lock_owner = M_CPU;
`endif

    assign expired = (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: if (arb_valid) state_d = ADDR;
            ADDR: state_d = bus_ready ? RESP : WAIT;
            WAIT: if (bus_ready || expired) state_d = RESP;
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q    <= M_CPU;
            last_grant <= M_DBG;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wd_q       <= '0;
            rd_q       <= '0;
            err_q      <= 1'b0;
            cnt        <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (arb_valid) begin
                        grant_q    <= winner;
                        last_grant <= winner;
                        addr_q     <= winner ? m1_addr : m0_addr;
                        we_q       <= winner ? m1_we : m0_we;
                        wd_q       <= winner ? m1_wd : m0_wd;
                    end
                end
                ADDR: begin
                    cnt <= CNT_W'(1);
                    if (bus_ready) rd_q <= bus_rd;
                end
                WAIT: begin
                    if (bus_ready) begin
                        rd_q <= bus_rd;
                    end else if (expired) begin
                        rd_q  <= '0;
                        err_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    err_q <= 1'b0;
                    cnt   <= '0;
                end
                default: ;
            endcase
        end
    end

    assign resp     = (state == RESP);
    assign busy     = (state != IDLE);
    assign grant    = grant_q;
    assign bus_addr = addr_q;
    assign bus_wd   = wd_q;
    // Write strobe only in ADDR so a stalled device is written once.
    assign bus_we   = (state == ADDR) && we_q;

    assign m0_ack = resp && (grant_q == M_CPU);
    assign m1_ack = resp && (grant_q == M_DBG);
    assign m0_rd  = m0_ack ? rd_q : '0;
    assign m1_rd  = m1_ack ? rd_q : '0;
    assign m0_err = m0_ack && err_q;
    assign m1_err = m1_ack && err_q;

endmodule

// File: tb/tb_devbus_arbiter.sv
// Directed bench for devbus_arbiter: handshake, round-robin, timeout, reset.
module tb_devbus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_we, m0_ack, m0_err;
    logic [29:0] m0_addr;
    logic [31:0] m0_wd, m0_rd;
    logic        m1_req, m1_we, m1_ack, m1_err;
    logic [29:0] m1_addr;
    logic [31:0] m1_wd, m1_rd;
    logic [29:0] bus_addr;
    logic [31:0] bus_wd, bus_rd;
    logic        bus_we, bus_ready, busy, grant;
`ifdef DEVBUS_LOCK_EN
    logic        m0_lock, m1_lock;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    devbus_arbiter #(.TIMEOUT(16), .ADDR_W(30)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef DEVBUS_LOCK_EN
        .m0_lock   (m0_lock),
        .m1_lock   (m1_lock),
`endif
        .m0_req    (m0_req),
        .m0_addr   (m0_addr),
        .m0_we     (m0_we),
        .m0_wd     (m0_wd),
        .m0_ack    (m0_ack),
        .m0_rd     (m0_rd),
        .m0_err    (m0_err),
        .m1_req    (m1_req),
        .m1_addr   (m1_addr),
        .m1_we     (m1_we),
        .m1_wd     (m1_wd),
        .m1_ack    (m1_ack),
        .m1_rd     (m1_rd),
        .m1_err    (m1_err),
        .bus_addr  (bus_addr),
        .bus_wd    (bus_wd),
        .bus_we    (bus_we),
        .bus_rd    (bus_rd),
        .bus_ready (bus_ready),
        .busy      (busy),
        .grant     (grant)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wd = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wd = '0;
        bus_rd = '0; bus_ready = 1'b1;
`ifdef DEVBUS_LOCK_EN
        m0_lock = 0; m1_lock = 0;
`endif
        tick(); tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_addr", 32'(bus_addr), 0);
        chk("rst_we", 32'(bus_we), 0);
        chk("rst_ack", 32'({m0_ack, m1_ack}), 0);

        // m0 read, single-cycle device
        rst_n = 1'b1;
        m0_req = 1; m0_addr = 30'h7F04; m0_we = 0; bus_rd = 32'hDEADBEEF;
        tick();
        chk("rd_addr_busy", 32'(busy), 1);
        chk("rd_addr_bus", 32'(bus_addr), 32'h7F04);
        chk("rd_addr_we", 32'(bus_we), 0);
        chk("rd_addr_noack", 32'(m0_ack), 0);
        tick();
        chk("rd_ack", 32'(m0_ack), 1);
        chk("rd_data", m0_rd, 32'hDEADBEEF);
        chk("rd_err", 32'(m0_err), 0);
        chk("rd_m1_ack", 32'(m1_ack), 0);
        chk("rd_resp_we", 32'(bus_we), 0);
        m0_req = 0;
        tick();
        chk("rd_idle_ack", 32'(m0_ack), 0);
        chk("rd_idle_rd", m0_rd, 0);
        chk("rd_idle_busy", 32'(busy), 0);

        // m1 write
        m1_req = 1; m1_addr = 30'h7F20; m1_we = 1; m1_wd = 32'hA5;
        tick();
        chk("wr_we", 32'(bus_we), 1);
        chk("wr_wd", bus_wd, 32'hA5);
        chk("wr_addr", 32'(bus_addr), 32'h7F20);
        chk("wr_grant", 32'(grant), 1);
        tick();
        chk("wr_we_off", 32'(bus_we), 0);
        chk("wr_ack", 32'(m1_ack), 1);
        chk("wr_m0_ack", 32'(m0_ack), 0);
        chk("wr_err", 32'(m1_err), 0);
        m1_req = 0; m1_we = 0;
        tick();

        // both masters continuously: grants alternate starting at m0
        m0_req = 1; m1_req = 1; m0_addr = 30'h100; m1_addr = 30'h200;
        for (int i = 0; i < 4; i++) begin
            bus_rd = 32'h1000 + 32'(i);
            tick();
            tick();
            chk("rr_grant", 32'(grant), 32'(i % 2));
            chk("rr_ack", 32'((i % 2) ? m1_ack : m0_ack), 1);
            chk("rr_other_ack", 32'((i % 2) ? m0_ack : m1_ack), 0);
            chk("rr_data", (i % 2) ? m1_rd : m0_rd, 32'h1000 + 32'(i));
            if (i == 3) begin
                m0_req = 0; m1_req = 0;
            end
            tick();
        end

        // timeout: ack 16 cycles after ADDR entry
        bus_ready = 0; bus_rd = 32'h55; m0_req = 1; m0_addr = 30'h10;
        tick();
        chk("to_addr_busy", 32'(busy), 1);
        for (int c = 1; c <= 15; c++) begin
            tick();
            chk("to_wait_noack", 32'(m0_ack), 0);
        end
        tick();
        chk("to_ack", 32'(m0_ack), 1);
        chk("to_err", 32'(m0_err), 1);
        chk("to_rd", m0_rd, 0);
        m0_req = 0;
        tick();
        chk("to_idle", 32'(busy), 0);
        chk("to_err_clr", 32'(m0_err), 0);

        // ready on the last counter value wins over timeout
        m1_req = 1; m1_addr = 30'h20;
        tick();
        for (int c = 1; c <= 15; c++) tick();
        chk("lr_noack", 32'(m1_ack), 0);
        bus_ready = 1; bus_rd = 32'hCAFEF00D;
        tick();
        chk("lr_ack", 32'(m1_ack), 1);
        chk("lr_err", 32'(m1_err), 0);
        chk("lr_rd", m1_rd, 32'hCAFEF00D);
        m1_req = 0;
        tick();

        // reset during WAIT
        bus_ready = 0; m1_req = 1; m1_we = 1; m1_wd = 32'h77; m1_addr = 30'h33;
        tick();
        chk("rw_we", 32'(bus_we), 1);
        tick();
        tick();
        rst_n = 0;
        #1;
        chk("rw_busy", 32'(busy), 0);
        chk("rw_ack", 32'({m0_ack, m1_ack}), 0);
        chk("rw_addr", 32'(bus_addr), 0);
        chk("rw_wd", bus_wd, 0);
        chk("rw_grant", 32'(grant), 0);
        tick();
        chk("rw_hold_ack", 32'(m1_ack), 0);
        rst_n = 1; bus_ready = 1; m1_we = 0;
        m0_req = 1; bus_rd = 32'h1234;
        tick();
        chk("ar_grant_m0", 32'(grant), 0);
        tick();
        chk("ar_m0_ack", 32'(m0_ack), 1);
        chk("ar_m0_rd", m0_rd, 32'h1234);
        m0_req = 0;
        tick();
        tick();
        chk("ar_grant_m1", 32'(grant), 1);
        tick();
        chk("ar_m1_ack", 32'(m1_ack), 1);
        m1_req = 0;
        tick();

`ifdef DEVBUS_LOCK_EN
        // m1 locks the bus for three transfers while m0 waits
        m1_req = 1; m1_lock = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tick();
            chk("lk_grant_m1", 32'(grant), 1);
            chk("lk_m1_ack", 32'(m1_ack), 1);
            if (i == 0) m0_req = 1;
            if (i == 2) begin
                m1_req = 0; m1_lock = 0;
            end
            tick();
        end
        tick();
        tick();
        chk("lk_grant_m0", 32'(grant), 0);
        chk("lk_m0_ack", 32'(m0_ack), 1);
        m0_req = 0;
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
